// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the 7-segment scan decoder:
//     SEG_W       width of the segment pattern (a..g)
//     SEG_IN_W    width of the seg_n pad bus (adds the decimal point when
//                 SEG7_DP_EN is defined)
//     SEG_BLANK   all segments off (active-low)
//     SEG_CODES   legal active-low patterns for hex digits 0..F
//     accept_act_e  what an accepted sample does to the capture state
//   Optional feature macro: SEG7_DP_EN (decimal point on seg_n[7]).
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_W = 7;

`ifdef SEG7_DP_EN
    localparam int SEG_IN_W = SEG_W + 1;
`else
    localparam int SEG_IN_W = SEG_W;
`endif

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Index i holds the seg_n[6:0] pattern that displays hex digit i.
    localparam logic [SEG_W-1:0] SEG_CODES [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0011000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    typedef enum logic [2:0] {
        NONE,     // blanking interval, nothing selected
        WRITE,    // one digit selected, legal hex pattern
        BLANK,    // one digit selected, all segments off
        BAD_SEG,  // one digit selected, unknown pattern
        BAD_SEL   // several digits selected at once
    } accept_act_e;

endpackage

// File: rtl/seg7_to_hex.sv
// -----------------------------------------------------------------------------
// seg7_to_hex
//   Combinational decoder from an active-low segment pattern to a hex nibble.
//   Ports:
//     seg_i     in   SEG_W  active-low segment pattern, bit0=a ... bit6=g
//     nibble_o  out  4      decoded value (0 when the pattern is not legal)
//     legal_o   out  1      pattern matches one of the 16 hex glyphs
//     blank_o   out  1      all segments off
// -----------------------------------------------------------------------------
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [3:0]       nibble_o,
    output logic             legal_o,
    output logic             blank_o
);

    // The 16 glyphs are distinct, so at most one entry can match.
    always_comb begin
        nibble_o = 4'h0;
        legal_o  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_CODES[i]) begin
                nibble_o = 4'(i);
                legal_o  = 1'b1;
            end
        end
    end

    assign blank_o = (seg_i == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//   Receive side of a multiplexed active-low 7-segment display bus. The pads
//   are synchronised, filtered for stability, checked against the legal hex
//   glyphs and assembled into a frame of NUM_DIGITS nibbles.
//
//   Parameters:
//     NUM_DIGITS     number of multiplexed digits (>= 1)
//     STABLE_CYCLES  consecutive equal samples before a pattern is accepted (>= 2)
//
//   Ports:
//     clk            in   1             system clock
//     rst_n          in   1             asynchronous active-low reset
//     seg_n          in   SEG_IN_W      segment lines, active-low, bit0=a..bit6=g
//                                       (bit7 = decimal point with SEG7_DP_EN)
//     dig_sel_n      in   NUM_DIGITS    digit selects, active-low one-hot,
//                                       all-ones = blanking
//     clear_i        in   1             synchronous clear of capture state
//     digits_o       out  4*NUM_DIGITS  decoded nibbles, digit d at [4d+3:4d]
//     digit_valid_o  out  NUM_DIGITS    digit d holds a legally decoded value
//     frame_o        out  1             pulse when every digit has been captured
//     frame_valid_o  out  1             all digits legal in the last frame
//     err_o          out  1             pulse on illegal pattern or multi-select
//     dp_o           out  NUM_DIGITS    decimal point per digit (SEG7_DP_EN only)
//
//   Optional feature macro: SEG7_DP_EN.
// -----------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEG_IN_W-1:0]     seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    input  logic                    clear_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   digit_valid_o,
    output logic                    frame_o,
    output logic                    frame_valid_o,
`ifdef SEG7_DP_EN
    output logic                    err_o,
    output logic [NUM_DIGITS-1:0]   dp_o
`else
    output logic                    err_o
`endif
);

    localparam int SMP_W = SEG_IN_W + NUM_DIGITS;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    // Parameter sanity checks at elaboration.
    if (NUM_DIGITS < 1) begin : g_bad_digits
        $error("NUM_DIGITS must be at least 1");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 2");
    end

    // -------------------------------------------------------------------------
    // Synchroniser, history and stability counter.
    // Selects and segments travel together so a sample is always a coherent
    // {sel, seg} pair.
    // -------------------------------------------------------------------------
    logic [SMP_W-1:0] sync1_q;
    logic [SMP_W-1:0] s_q;
    logic [SMP_W-1:0] p_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            s_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {dig_sel_n, seg_n};
            s_q     <= sync1_q;
            p_q     <= s_q;
            cnt_q   <= cnt_d;
        end
    end

    // The counter saturates one above the accept point, so a long stable
    // period produces exactly one accept.
    always_comb begin
        cnt_d = cnt_q;
        if (s_q != p_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign accept = (s_q == p_q) && (cnt_q == CNT_W'(STABLE_CYCLES - 1));

    // -------------------------------------------------------------------------
    // Pattern classification of the current synchronised sample.
    // -------------------------------------------------------------------------
    logic [SEG_IN_W-1:0]   s_seg;
    logic [NUM_DIGITS-1:0] s_sel;
    logic [NUM_DIGITS-1:0] sel_low;
    logic [3:0]            nibble;
    logic                  legal;
    logic                  blank;
    accept_act_e           act;

    assign s_seg   = s_q[SEG_IN_W-1:0];
    assign s_sel   = s_q[SMP_W-1:SEG_IN_W];
    assign sel_low = ~s_sel;

    // Legality only ever looks at segments a..g; the decimal point is separate.
    seg7_to_hex u_to_hex (
        .seg_i    (s_seg[SEG_W-1:0]),
        .nibble_o (nibble),
        .legal_o  (legal),
        .blank_o  (blank)
    );

    // x & (x-1) is non-zero exactly when more than one bit of x is set.
    always_comb begin
        act = NONE;
        if (accept) begin
            if (sel_low == '0) begin
                act = NONE;
            end else if ((sel_low & (sel_low - NUM_DIGITS'(1))) != '0) begin
                act = BAD_SEL;
            end else if (legal) begin
                act = WRITE;
            end else if (blank) begin
                act = BLANK;
            end else begin
                act = BAD_SEG;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Capture state and frame assembly.
    // -------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q,  valid_d;
    logic [NUM_DIGITS-1:0]   seen_q,   seen_d;
    logic                    frame_q,  frame_d;
    logic                    fvalid_q, fvalid_d;
    logic                    err_q,    err_d;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dp_q,     dp_d;
`endif

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        fvalid_d = fvalid_q;
        frame_d  = 1'b0;
        err_d    = 1'b0;
`ifdef SEG7_DP_EN
        dp_d     = dp_q;
`endif
        if (clear_i) begin
            // Clear wins; a coincident accept is discarded entirely.
            digits_d = '0;
            valid_d  = '0;
            seen_d   = '0;
            fvalid_d = 1'b0;
        end else begin
            case (act)
                WRITE, BLANK, BAD_SEG: begin
                    for (int d = 0; d < NUM_DIGITS; d++) begin
                        if (sel_low[d]) begin
                            if (act == WRITE) begin
                                digits_d[4*d +: 4] = nibble;
                                valid_d[d]         = 1'b1;
                            end else begin
                                valid_d[d]         = 1'b0;
                            end
                            seen_d[d] = 1'b1;
`ifdef SEG7_DP_EN
                            dp_d[d]   = ~s_seg[SEG_W];
`endif
                        end
                    end
                    err_d = (act == BAD_SEG);
                    // Frame closes on the same edge that stores its last digit.
                    if (&seen_d) begin
                        frame_d  = 1'b1;
                        fvalid_d = &valid_d;
                        seen_d   = '0;
                    end
                end
                BAD_SEL: begin
                    err_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            fvalid_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef SEG7_DP_EN
            dp_q     <= '0;
`endif
        end else begin
            digits_q <= digits_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            fvalid_q <= fvalid_d;
            err_q    <= err_d;
`ifdef SEG7_DP_EN
            dp_q     <= dp_d;
`endif
        end
    end

    assign digits_o      = digits_q;
    assign digit_valid_o = valid_q;
    assign frame_o       = frame_q;
    assign frame_valid_o = fvalid_q;
    assign err_o         = err_q;
`ifdef SEG7_DP_EN
    assign dp_o          = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//   Directed bench for seg7_scan_decoder with NUM_DIGITS=4, STABLE_CYCLES=4.
//   Inputs change 1 ns after a rising edge; outputs are read at the same point
//   and err_o / frame_o pulses are counted on falling edges.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int ND   = 4;
    localparam int SC   = 4;
    localparam int HOLD = 8;
    localparam int NV   = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg_n;
    logic [ND-1:0] dig_sel_n;
    logic          clear_i;
    logic [4*ND-1:0] digits_o;
    logic [ND-1:0] digit_valid_o;
    logic          frame_o;
    logic          frame_valid_o;
    logic          err_o;
`ifdef SEG7_DP_EN
    logic [ND-1:0] dp_o;
`endif

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int frame_pulses = 0;
    int eb, fb;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef SEG7_DP_EN
        .seg_n         ({1'b1, seg_n}),
        .dp_o          (dp_o),
`else
        .seg_n         (seg_n),
`endif
        .dig_sel_n     (dig_sel_n),
        .clear_i       (clear_i),
        .digits_o      (digits_o),
        .digit_valid_o (digit_valid_o),
        .frame_o       (frame_o),
        .frame_valid_o (frame_valid_o),
        .err_o         (err_o)
    );

    always @(negedge clk) begin
        if (err_o)   err_pulses++;
        if (frame_o) frame_pulses++;
    end

    typedef struct {
        logic [3:0]  sel;
        logic [6:0]  seg;
        logic [15:0] digits;
        logic [3:0]  valid;
        int          n_err;
        int          n_frame;
        logic        fvalid;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg);
        dig_sel_n = sel;
        seg_n     = seg;
    endtask

    // Hold one pad value for HOLD cycles and check the resulting state.
    task automatic hold_check(input string name, input logic [3:0] sel, input logic [6:0] seg,
                              input logic [15:0] digits, input logic [3:0] valid,
                              input int n_err, input int n_frame, input logic fvalid);
        int e0, f0;
        e0 = err_pulses;
        f0 = frame_pulses;
        drive(sel, seg);
        step(HOLD);
        chk({name, " digits"}, 32'(digits_o), 32'(digits));
        chk({name, " valid"},  32'(digit_valid_o), 32'(valid));
        chk({name, " fvalid"}, 32'(frame_valid_o), 32'(fvalid));
        chk({name, " errs"},   32'(err_pulses - e0), 32'(n_err));
        chk({name, " frames"}, 32'(frame_pulses - f0), 32'(n_frame));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " digits"}, 32'(digits_o), 32'h0);
        chk({name, " valid"},  32'(digit_valid_o), 32'h0);
        chk({name, " frame"},  32'(frame_o), 32'h0);
        chk({name, " fvalid"}, 32'(frame_valid_o), 32'h0);
        chk({name, " err"},    32'(err_o), 32'h0);
    endtask

    initial begin
        // sel, seg, digits, valid, n_err, n_frame, fvalid
        vecs[0]  = '{4'b1011, 7'b0111111, 16'h0002, 4'b0001, 1, 0, 1'b0}; // bad glyph on digit 2
        vecs[1]  = '{4'b1101, 7'b1111000, 16'h0072, 4'b0011, 0, 0, 1'b0}; // 7
        vecs[2]  = '{4'b0111, 7'b0011000, 16'h9072, 4'b1011, 0, 1, 1'b0}; // 9, frame with bad digit
        vecs[3]  = '{4'b1110, 7'b1111001, 16'h9071, 4'b1011, 0, 0, 1'b0}; // 1
        vecs[4]  = '{4'b1101, 7'b0100100, 16'h9021, 4'b1011, 0, 0, 1'b0}; // 2
        vecs[5]  = '{4'b1011, 7'b0110000, 16'h9321, 4'b1111, 0, 0, 1'b0}; // 3
        vecs[6]  = '{4'b0111, 7'b0011001, 16'h4321, 4'b1111, 0, 1, 1'b1}; // 4, clean frame
        vecs[7]  = '{4'b1110, 7'b0010010, 16'h4325, 4'b1111, 0, 0, 1'b1}; // 5
        vecs[8]  = '{4'b1101, 7'b0000010, 16'h4365, 4'b1111, 0, 0, 1'b1}; // 6
        vecs[9]  = '{4'b1011, 7'b1111000, 16'h4765, 4'b1111, 0, 0, 1'b1}; // 7
        vecs[10] = '{4'b0111, 7'b1111111, 16'h4765, 4'b0111, 0, 1, 1'b0}; // blank digit 3
        vecs[11] = '{4'b1100, 7'b0000000, 16'h4765, 4'b0111, 1, 0, 1'b0}; // multi-select
        vecs[12] = '{4'b1110, 7'b0001000, 16'h476A, 4'b0111, 0, 0, 1'b0}; // A
        vecs[13] = '{4'b1101, 7'b0000011, 16'h47BA, 4'b0111, 0, 0, 1'b0}; // b
        vecs[14] = '{4'b1011, 7'b1000110, 16'h4CBA, 4'b0111, 0, 0, 1'b0}; // C
        vecs[15] = '{4'b0111, 7'b0100001, 16'hDCBA, 4'b1111, 0, 1, 1'b1}; // d
        vecs[16] = '{4'b1110, 7'b0000110, 16'hDCBE, 4'b1111, 0, 0, 1'b1}; // E
        vecs[17] = '{4'b1101, 7'b0001110, 16'hDCFE, 4'b1111, 0, 0, 1'b1}; // F
        vecs[18] = '{4'b1110, 7'b1000000, 16'hDCF0, 4'b1111, 0, 0, 1'b1}; // 0, recapture digit 0
        vecs[19] = '{4'b1111, 7'b0000000, 16'hDCF0, 4'b1111, 0, 0, 1'b1}; // no select: ignored

        // Power-on reset
        rst_n   = 1'b0;
        clear_i = 1'b0;
        drive(4'b1111, 7'b1111111);
        step(3);
        chk_all_zero("por");
        rst_n = 1'b1;
        step(4);

        // First accept lands on edge 6, not edge 5
        eb = err_pulses;
        fb = frame_pulses;
        drive(4'b1110, 7'b0100100);
        step(6);
        chk("lat e5 valid", 32'(digit_valid_o), 32'h0);
        chk("lat e5 digits", 32'(digits_o), 32'h0);
        step(1);
        chk("lat e6 valid", 32'(digit_valid_o), 32'h1);
        chk("lat e6 digits", 32'(digits_o), 32'h2);
        step(3);
        chk("lat errs", 32'(err_pulses - eb), 32'h0);
        chk("lat frames", 32'(frame_pulses - fb), 32'h0);

        // Three-edge glitch on digit 1 is filtered out
        eb = err_pulses;
        drive(4'b1101, 7'b1111001);
        step(3);
        drive(4'b1111, 7'b1111111);
        step(HOLD);
        chk("glitch valid", 32'(digit_valid_o), 32'h1);
        chk("glitch digits", 32'(digits_o), 32'h2);
        chk("glitch errs", 32'(err_pulses - eb), 32'h0);

        for (int i = 0; i < NV; i++) begin
            hold_check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].seg, vecs[i].digits,
                       vecs[i].valid, vecs[i].n_err, vecs[i].n_frame, vecs[i].fvalid);
        end

        // clear_i on the accept edge drops the accept
        eb = err_pulses;
        fb = frame_pulses;
        drive(4'b1110, 7'b0001000);
        step(6);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        chk("clr valid", 32'(digit_valid_o), 32'h0);
        chk("clr digits", 32'(digits_o), 32'h0);
        chk("clr fvalid", 32'(frame_valid_o), 32'h0);
        step(6);
        chk("clr later valid", 32'(digit_valid_o), 32'h0);
        chk("clr errs", 32'(err_pulses - eb), 32'h0);
        chk("clr frames", 32'(frame_pulses - fb), 32'h0);

        // Reset mid-frame discards the partial frame
        hold_check("pre d0", 4'b1110, 7'b1111001, 16'h0001, 4'b0001, 0, 0, 1'b0);
        hold_check("pre d1", 4'b1101, 7'b0100100, 16'h0021, 4'b0011, 0, 0, 1'b0);
        #1;
        rst_n = 1'b0;
        #2;
        chk_all_zero("async rst");
        drive(4'b1111, 7'b1111111);
        step(2);
        rst_n = 1'b1;
        step(3);
        hold_check("post d2", 4'b1011, 7'b0110000, 16'h0300, 4'b0100, 0, 0, 1'b0);
        hold_check("post d3", 4'b0111, 7'b0011001, 16'h4300, 4'b1100, 0, 0, 1'b0);
        hold_check("post d0", 4'b1110, 7'b0010010, 16'h4305, 4'b1101, 0, 0, 1'b0);
        hold_check("post d1", 4'b1101, 7'b0000010, 16'h4365, 4'b1111, 0, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the 7-segment display interface. Samples a multiplexed, active-low 7-segment bus (segment lines plus per-digit selects) and recovers one hex nibble per digit.
- Used for loopback self-test of our display drivers and to capture display traffic from external boards.
- Applies synchronisation, a stability filter, legal-pattern checking and frame assembly.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digits (>=1).
- STABLE_CYCLES, 4, consecutive equal samples needed before a pattern is accepted (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_n  in  7  segment lines, active-low; bit0=a ... bit6=g
- dig_sel_n  in  NUM_DIGITS  digit selects, active-low one-hot; all-ones means blanking
- clear_i  in  1  synchronous clear of capture state
- digits_o  out  4*NUM_DIGITS  decoded nibbles; digit d at [4d+3:4d]
- digit_valid_o  out  NUM_DIGITS  digit d holds a legally decoded value
- frame_o  out  1  one-cycle pulse when every digit has been captured since the last frame
- frame_valid_o  out  1  all digits were legal in the last completed frame
- err_o  out  1  one-cycle pulse on an illegal pattern or multi-select

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: all outputs are 0. Synchroniser, history, counter and seen-mask are also 0. Reset mid-frame discards the partial frame.
- Synchroniser: seg_n and dig_sel_n pass through 2 flops. The history register p holds the previous synchronised sample s.
- Counter cnt:
  - Cleared when s != p.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - accept = (s==p) && (cnt==STABLE_CYCLES-1). It fires exactly once per stable period.
- Timing:
  - Edge 0 is the first edge that samples a new pad value.
  - Outputs update on edge STABLE_CYCLES+2.
  - A pad value held for fewer than STABLE_CYCLES+1 sampling edges is never accepted.
- On accept, by s.sel:
  - All ones: no action.
  - More than one low bit: err_o pulse; no register change.
  - Exactly one low bit d, legal code for 0..F: digits_o[d] <= nibble; digit_valid_o[d] <= 1; seen[d] <= 1.
  - Exactly one low bit d, seg all ones (blank): digit_valid_o[d] <= 0; seen[d] <= 1; no error.
  - Exactly one low bit d, any other code: digit_valid_o[d] <= 0; seen[d] <= 1; err_o pulse.
- Legal codes, as seg_n[6:0]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Frame completion:
  - When the accept would make seen all-ones, frame_o pulses on the same edge the digit updates.
  - frame_valid_o <= AND of the updated digit_valid_o.
  - seen clears to 0 on that edge.
  - Re-capturing an already-seen digit before the frame completes overwrites its value; no error.
- clear_i: clears digit_valid_o, seen, frame_valid_o and digits_o. It has priority over a simultaneous accept, which is dropped. cnt and p are unaffected.
- err_o and frame_o are never asserted for more than one cycle per accept.

Optional Feature:
- SEG7_DP_EN
- Defined:
  - seg_n widens to 8 bits, with bit7 = decimal point.
  - Adds port dp_o (out, NUM_DIGITS).
  - dp_o[d] <= ~seg_n[7] on every accept for digit d, including blank and illegal patterns.
  - The legality check uses bits [6:0] only.
- Undefined: 7-bit seg_n and no dp_o.

Decomposition:
- seg7_pkg holds:
  - SEG_W = 7
  - the 16-entry legal-code constant array
  - SEG_BLANK = 7'b1111111
  - a typedef for the accept-action enum: NONE, WRITE, BLANK, BAD_SEG, BAD_SEL
- Sub-module seg7_to_hex: combinational pattern-to-nibble decoder with outputs nibble[3:0], legal, blank. Instantiated once on s.seg.

Test Plan (NUM_DIGITS=4, STABLE_CYCLES=4):
- Reset: assert rst_n=0 mid-operation → all outputs 0 asynchronously; after release the next full frame is required before frame_o.
- dig_sel_n=1110, seg_n=0100100 held 10 cycles → digits_o[3:0]=2 and digit_valid_o=0001 at edge 6; exactly one accept; no err_o.
- seg_n=1111001 pulsed for 3 edges on digit 1, then back to blank → no update, no err_o.
- Digit 2 with seg_n=0111111 held → err_o single pulse; digit_valid_o[2]=0; seen[2]=1.
- Scan digits 0..3 with codes for 1,2,3,4, each held 8 cycles → one frame_o pulse; frame_valid_o=1; digits_o=16'h4321. Repeat with digit 3 blank → frame_valid_o=0.
- dig_sel_n=1100 held → err_o pulse, outputs unchanged. Assert clear_i on the same cycle as a digit-0 accept → accept dropped and all valid bits 0.
